// File: rtl/fifo_out_pack.sv
// FFT return-path packer: keeps the first KEEP_POINTS points of each range bin,
// packs sample pairs into 32-bit words and buffers them in a FWFT FIFO.
module fifo_out_pack #(
  parameter int unsigned NFFT        = 50,
  parameter int unsigned KEEP_POINTS = 24,
  parameter int unsigned NUM_BINS    = 4,
  parameter int unsigned DEPTH_LOG2  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           data_in,
  input  logic                  data_valid,
  output logic [31:0]           data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fill_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam int unsigned BW    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t          state;
  logic [PW-1:0]   point_cnt;
  logic [BW-1:0]   bin_cnt;
  logic            phase;
  logic [15:0]     hold;
  logic            wr_pend;
  logic [31:0]     wr_data;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         mem_cnt;

  logic rd_c;
  logic wr_ok_c;
  logic load_c;

  // fill_count includes the word held in the output register; mem_cnt does not.
  assign rd_c    = out_valid & out_ready;
  assign wr_ok_c = wr_pend & ((fill_count < CW'(DEPTH)) | rd_c);
  assign load_c  = (mem_cnt != '0) & (~out_valid | rd_c);

  // Frame control: sample counting, pair packing and end-of-frame detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      point_cnt  <= '0;
      bin_cnt    <= '0;
      phase      <= 1'b0;
      hold       <= '0;
      wr_pend    <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_pend    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            point_cnt <= '0;
            bin_cnt   <= '0;
            phase     <= 1'b0;
          end
        end
        COLLECT: begin
          if (data_valid) begin
            if (32'(point_cnt) < KEEP_POINTS) begin
              if (!phase) begin
                hold <= data_in;
              end else begin
                wr_data <= {hold, data_in};
                wr_pend <= 1'b1;
              end
              phase <= ~phase;
            end
            if (point_cnt == PW'(NFFT - 1)) begin
              point_cnt <= '0;
              if (bin_cnt == BW'(NUM_BINS - 1)) begin
                state <= DRAIN;
              end else begin
                bin_cnt <= bin_cnt + 1'b1;
              end
            end else begin
              point_cnt <= point_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((fill_count == '0) && !wr_pend) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the first-word-fall-through output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok_c) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load_c) begin
        data_out  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (rd_c) begin
        out_valid <= 1'b0;
      end
      mem_cnt    <= mem_cnt + CW'(wr_ok_c) - CW'(load_c);
      fill_count <= fill_count + CW'(wr_ok_c) - CW'(rd_c);
      if ((state == IDLE) && start) begin
        overflow <= 1'b0;
      end else if (wr_pend && !wr_ok_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
